adc_temp_reader: RTL and testbench

ADC_TEMP_READER -- requirements
Module: adc_temp_reader

---
 rtl/adc_temp_reader.sv | 144 ++++++++++++++
 tb/tb_adc_temp_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_temp_reader.sv
// adc_temp_reader: scans NUM_CH thermistor channels over a 16-bit SPI ADC frame and latches 12-bit codes.
// Optional range-fault detection is built only when ADC_RANGE_CHECK_EN is defined.
module adc_temp_reader #(
  parameter int CLK_DIV = 25,
  parameter int NUM_CH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic                  adc_cs_n,
  output logic                  adc_sclk,
  output logic                  adc_din,
  input  logic                  adc_dout,
  output logic [NUM_CH*12-1:0]  temp_bus,
  output logic                  sample_valid,
  output logic [2:0]            sample_ch,
  output logic [NUM_CH-1:0]     fault
);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state_q, state_d;
  logic [8:0] div_q, div_d;
  logic [4:0] cnt_q, cnt_d;
  logic [11:0] sh_q, sh_d;
  logic [2:0] next_q, next_d, prev_q, prev_d, ch_q, ch_d;
  logic cs_q, cs_d, sclk_q, sclk_d, din_q, din_d;
  logic discard_q, discard_d, wr_q, wr_d, valid_q, valid_d;
  logic [NUM_CH*12-1:0] temp_q, temp_d;
  logic half_end, gap_end;
  assign half_end = div_q == 9'(CLK_DIV - 1);
  assign gap_end  = div_q == 9'(2 * CLK_DIV - 1);
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    next_d    = next_q;
    prev_d    = prev_q;
    ch_d      = ch_q;
    cs_d      = cs_q;
    sclk_d    = sclk_q;
    din_d     = din_q;
    discard_d = discard_q;
    wr_d      = 1'b0;
    valid_d   = 1'b0;
    temp_d    = temp_q;
    for (int c = 0; c < NUM_CH; c++)
      if (wr_q && ch_q == 3'(c)) temp_d[12*c +: 12] = sh_q;
    valid_d = wr_q;
    case (state_q)
      IDLE: if (enable) begin
        state_d = SHIFT;
        cs_d    = 1'b0;
        div_d   = '0;
        cnt_d   = '0;
      end
      SHIFT: begin
        div_d = half_end ? 9'd0 : div_q + 9'd1;
        if (half_end) begin
          sclk_d = !sclk_q;
          if (sclk_q) begin
            // falling edge: bits 2..4 carry the next address MSB first
            din_d = (cnt_q == 5'd2 && next_q[2]) || (cnt_q == 5'd3 && next_q[1]) ||
                    (cnt_q == 5'd4 && next_q[0]);
            cnt_d = cnt_q + 5'd1;
          end else begin
            sh_d = {sh_q[10:0], adc_dout};
            if (cnt_q == 5'd16) begin
              state_d   = GAP;
              cs_d      = 1'b1;
              din_d     = 1'b0;
              div_d     = '0;
              wr_d      = !discard_q;
              ch_d      = discard_q ? ch_q : prev_q;
              prev_d    = next_q;
              next_d    = (next_q == 3'(NUM_CH - 1)) ? 3'd0 : next_q + 3'd1;
              discard_d = 1'b0;
            end
          end
        end
      end
      GAP: begin
        div_d = gap_end ? 9'd0 : div_q + 9'd1;
        if (gap_end) begin
          cnt_d     = '0;
          state_d   = enable ? SHIFT : IDLE;
          cs_d      = !enable;
          discard_d = !enable;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      next_q    <= '0;
      prev_q    <= '0;
      ch_q      <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
      din_q     <= 1'b0;
      discard_q <= 1'b1;
      wr_q      <= 1'b0;
      valid_q   <= 1'b0;
      temp_q    <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      next_q    <= next_d;
      prev_q    <= prev_d;
      ch_q      <= ch_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      din_q     <= din_d;
      discard_q <= discard_d;
      wr_q      <= wr_d;
      valid_q   <= valid_d;
      temp_q    <= temp_d;
    end
  end
`ifdef ADC_RANGE_CHECK_EN
  logic [NUM_CH-1:0] fault_q;
  always_ff @(posedge clk) begin
    if (!rst_n) fault_q <= '0;
    else
      for (int c = 0; c < NUM_CH; c++)
        if (wr_q && ch_q == 3'(c)) fault_q[c] <= (sh_q >= 12'd4090) || (sh_q <= 12'd5);
  end
  assign fault = fault_q;
`else
  assign fault = '0;
`endif
  assign adc_cs_n     = cs_q;
  assign adc_sclk     = sclk_q;
  assign adc_din      = din_q;
  assign temp_bus     = temp_q;
  assign sample_valid = valid_q;
  assign sample_ch    = ch_q;
endmodule

// File: tb/tb_adc_temp_reader.sv
// tb_adc_temp_reader: directed bench with a pipelined SPI ADC model and SCLK/CS timing monitor.
module tb_adc_temp_reader;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, adc_dout = 1'b0;
  logic adc_cs_n, adc_sclk, adc_din, sample_valid;
  logic [23:0] temp_bus;
  logic [2:0] sample_ch;
  logic [1:0] fault;
  int total = 0, bad = 0;
  logic [11:0] mdata [2];
  logic [11:0] md;
  logic [2:0] cur = 3'd0, addr = 3'd0;
  int mk = 0;
  bit din_bad = 1'b0;
  int vcount = 0, csf = 0, csr = 0, len = 0, falls = 0;
  int ph_min = 99, ph_max = 0, gap = 0, last_gap = 0, last_falls = 0;
  logic [2:0] vch;
  logic [23:0] vtemp;
  logic [1:0] vfault;
  logic cs_p = 1'b1, sclk_p = 1'b1;

  adc_temp_reader #(.CLK_DIV(4), .NUM_CH(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .adc_din(adc_din), .adc_dout(adc_dout), .temp_bus(temp_bus), .sample_valid(sample_valid),
    .sample_ch(sample_ch), .fault(fault)
  );

  initial forever #5 clk = ~clk;

  // ADC: returns the channel addressed in the previous frame
  initial forever begin
    @(negedge adc_sclk);
    if (!adc_cs_n) begin
      md = mdata[cur[0]];
      adc_dout = (mk >= 4) ? md[15-mk] : 1'b0;
      mk++;
    end
  end
  initial forever begin
    @(posedge adc_sclk);
    if (!adc_cs_n) begin
      if (mk >= 3 && mk <= 5) addr = {addr[1:0], adc_din};
      else if (adc_din) din_bad = 1'b1;
    end
  end
  initial forever begin
    @(posedge adc_cs_n);
    cur = addr;
    mk = 0;
  end

  initial forever begin
    @(negedge clk);
    if (sample_valid) begin
      vcount++;
      vch = sample_ch;
      vtemp = temp_bus;
      vfault = fault;
    end
    if (cs_p && !adc_cs_n) begin
      last_gap = gap;
      len = 1;
      falls = 0;
      csf++;
    end else if (!adc_cs_n || !cs_p) begin
      if (adc_sclk != sclk_p) begin
        if (len < ph_min) ph_min = len;
        if (len > ph_max) ph_max = len;
        len = 1;
        if (!adc_sclk) falls++;
      end else len++;
      if (adc_cs_n) begin
        last_falls = falls;
        gap = 1;
        csr++;
      end
    end else gap++;
    cs_p = adc_cs_n;
    sclk_p = adc_sclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rise(input string tag);
    int n0 = csr;
    int i = 0;
    while (csr == n0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (csr == n0) begin
      total++;
      bad++;
      $error("FAIL %s: no adc_cs_n rise within 400 clk", tag);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n0 = vcount;
    int i = 0;
    while (vcount == n0 && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (vcount == n0) begin
      total++;
      bad++;
      $error("FAIL %s: no sample_valid within 400 clk", tag);
    end
  endtask

  task automatic wait_bit(input string tag, input int m, input logic [2:0] a, input bit use_a);
    int i = 0;
    while (!(!adc_cs_n && mk == m && (!use_a || addr == a)) && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (i >= 400) begin
      total++;
      bad++;
      $error("FAIL %s: bit position not reached within 400 clk", tag);
    end
  endtask

  initial begin
    int n;
    mdata[0] = 12'h3A5;
    mdata[1] = 12'h7F0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(adc_cs_n), 1);
    chk("rst_sclk", 32'(adc_sclk), 1);
    chk("rst_din", 32'(adc_din), 0);
    chk("rst_temp", 32'(temp_bus), 0);
    chk("rst_valid", 32'(sample_valid), 0);
    chk("rst_ch", 32'(sample_ch), 0);
    chk("rst_fault", 32'(fault), 0);
    rst_n = 1'b1;
    enable = 1'b1;
    wait_rise("frame1");
    @(negedge clk);
    @(negedge clk);
    chk("discard_first", vcount, 0);
    wait_valid("v1");
    chk("v1_ch", 32'(vch), 0);
    chk("v1_temp0", 32'(vtemp[11:0]), 32'h3A5);
    chk("din_addr_ch1", 32'(cur), 32'b001);
    wait_valid("v2");
    chk("v2_ch", 32'(vch), 1);
    chk("v2_temp1", 32'(vtemp[23:12]), 32'h7F0);
    wait_valid("v3");
    chk("v3_ch", 32'(vch), 0);
    chk("v3_temp_bus", 32'(temp_bus), 32'h7F03A5);
    chk("v3_fault", 32'(vfault), 0);
    chk("sclk_phase_min", ph_min, 4);
    chk("sclk_phase_max", ph_max, 4);
    chk("falls_per_frame", last_falls, 16);
    chk("cs_gap", last_gap, 8);
    chk("din_zero_elsewhere", 32'(din_bad), 0);
    mdata[0] = 12'h123;
    wait_bit("dis_k7", 8, 3'b001, 1'b1);
    enable = 1'b0;
    wait_valid("v_dis");
    chk("dis_ch", 32'(vch), 0);
    chk("dis_temp0", 32'(vtemp[11:0]), 32'h123);
    n = csf;
    repeat (300) @(negedge clk);
    chk("idle_no_frame", csf, n);
    chk("idle_cs_n", 32'(adc_cs_n), 1);
    chk("idle_hold", 32'(temp_bus), 32'h7F0123);
    n = vcount;
    enable = 1'b1;
    wait_rise("reen");
    @(negedge clk);
    @(negedge clk);
    chk("reen_discard", vcount, n);
    wait_valid("v_reen");
    chk("reen_ch", 32'(vch), 0);
    wait_bit("rst_k10", 11, 3'b000, 1'b0);
    n = vcount;
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_cs_n", 32'(adc_cs_n), 1);
    chk("abort_valid", 32'(sample_valid), 0);
    chk("abort_temp", 32'(temp_bus), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_rise("post_rst");
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_discard", vcount, n);
    wait_valid("v_post");
    chk("post_ch", 32'(vch), 0);
    chk("post_temp0", 32'(vtemp[11:0]), 32'h123);
`ifdef ADC_RANGE_CHECK_EN
    mdata[0] = 12'd4095;
    mdata[1] = 12'd2000;
    wait_valid("f1a");
    wait_valid("f1b");
    chk("fault_open", 32'(fault), 32'b01);
    mdata[0] = 12'd1000;
    wait_valid("f2a");
    wait_valid("f2b");
    chk("fault_clear", 32'(fault), 0);
`else
    wait_valid("f_off");
    chk("fault_off", 32'(vfault), 0);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
